multi_button_debouncer: RTL and testbench
=========================================

// Module: multi_button_debouncer
// PURPOSE
//  N-channel push-button conditioner for the sandbox top level; successor to the single-channel debouncer.
//  Runs on masterClock only, with an internal tick prescaler instead of an external slow clock.
//  Per channel: synchroniser, debounced level, one-cycle press/release pulses, long-press pulse with optional auto-repeat.
//  Outputs drive the resetter, SandboxProcess triggers and LEDs.
// PARAMETERS
//  CHANNELS      4      number of button inputs (>=1)
//  TICK_DIVIDER  12000  masterClock cycles per sample tick (>=2); 1 kHz at 12 MHz
//  STABLE_TICKS  20     consecutive agreeing ticks needed to change debounced level (>=1)
//  HOLD_TICKS    1000   ticks of debounced level=1 before first held pulse (>=1)
//  AUTO_REPEAT   0      1: repeat held every REPEAT_TICKS while still pressed; 0: single held pulse
//  REPEAT_TICKS  250    ticks between repeat held pulses (>=1; ignored if AUTO_REPEAT=0)
//  POLARITY      {CHANNELS{1'b0}}  per-channel bit; 1 = button active-low (raw inverted before sync)
// PORTS
//  masterClock  in   1         system clock (12 MHz)
//  reset        in   1         asynchronous, active-low reset
//  buttons      in   CHANNELS  raw asynchronous button pins
//  level        out  CHANNELS  debounced state, 1 = pressed
//  pressed      out  CHANNELS  1-cycle pulse on confirmed press
//  released     out  CHANNELS  1-cycle pulse on confirmed release
//  held         out  CHANNELS  1-cycle pulse on long press (and repeats)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; prescaler=0; sync flops=inactive; all channels RELEASED; counters 0.
//  Input: raw ^ POLARITY[i] -> 2-FF synchroniser -> s[i]; 2-cycle latency, no other filtering.
//  Prescaler: counts 0..TICK_DIVIDER-1, wraps; tick=1 for one cycle when count==TICK_DIVIDER-1; shared by all channels.
//  Per-channel FSM (channels fully independent; simultaneous events on different channels all honoured in the same cycle):
//   RELEASED:    s=1 -> PRESS_CHK, dbCnt=0.
//   PRESS_CHK:   s=0 (any cycle) -> RELEASED, dbCnt=0.
//                tick & s=1 -> dbCnt++; on the tick making dbCnt==STABLE_TICKS -> PRESSED,
//                level<=1, pressed pulse next cycle, holdCnt=0.
//   PRESSED:     s=0 -> RELEASE_CHK, dbCnt=0.
//   RELEASE_CHK: s=1 -> PRESSED (glitch; no released pulse).
//                tick & s=0 -> dbCnt++; on the tick making dbCnt==STABLE_TICKS -> RELEASED,
//                level<=0, released pulse, holdCnt=0.
//  Hold timer: holdCnt increments on every tick while level=1 (both PRESSED and RELEASE_CHK);
//   release glitches do not clear it.
//   holdCnt saturates at max(HOLD_TICKS, REPEAT_TICKS) when AUTO_REPEAT=0.
//   On the tick where holdCnt becomes HOLD_TICKS -> held pulse.
//   AUTO_REPEAT=1: afterwards, held pulses every REPEAT_TICKS ticks (repCnt reloads) until level falls.
//  Pulses are registered, exactly one cycle wide, never asserted during or in the cycle after reset.
//  pressed and held never coincide unless HOLD_TICKS... (cannot: holdCnt starts after press).
//  released cancels pending hold/repeat.
//  Counter widths: $clog2(max(STABLE_TICKS,HOLD_TICKS,REPEAT_TICKS)+1); prescaler $clog2(TICK_DIVIDER).
//  No overflow permitted.
//  Press latency from clean edge: 2 cycles sync + time to STABLE_TICKS-th tick + 1 register cycle.
//  Reset mid-operation: immediate return to reset values.
//   After release of reset, a still-held button is re-debounced from RELEASED and produces a fresh pressed pulse.
// TESTING  (CHANNELS=2, TICK_DIVIDER=4, STABLE_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4, POLARITY=2'b10)
//  1. buttons[0]=1 for 20 ticks, then 0 -> exactly one pressed[0] after 3rd tick; level[0]=1;
//     held[0] once at 10th tick of level; one released[0] 3 ticks after drop; ch1 silent.
//  2. buttons[0] toggling every 3 cycles for 60 cycles, then 0 -> level[0] stays 0; zero pulses.
//  3. AUTO_REPEAT=1, buttons[0] held 30 ticks after press -> held[0] at level ticks 10,14,18,22,26,30 (6 pulses);
//     AUTO_REPEAT=0 -> exactly 1.
//  4. 1-tick low glitch on buttons[0] during level=1 at tick 5 -> no released[0];
//     held[0] still at tick 10.
//  5. buttons[0]=1 and buttons[1]=0 (active-low) in same cycle -> pressed[0] and pressed[1] in same cycle;
//     buttons[1]=1 idle -> level[1]=0.
//  6. reset=0 at hold tick 6 with buttons[0]=1 -> all outputs 0 asynchronously;
//     reset=1 -> new pressed[0] after 3 ticks, held[0] 10 ticks later.

Source files
------------

// File: rtl/multi_button_debouncer_if.sv
// Button bundle between the pin side and the debouncer: raw pins in, conditioned
// level and event pulses out.
interface multi_button_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] buttons;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] held;

  modport master (output buttons, input level, input pressed, input released, input held);
  modport slave  (input buttons, output level, output pressed, output released, output held);
endinterface

// File: rtl/multi_button_debouncer.sv
// N-channel push-button conditioner: synchroniser, tick-sampled debounce FSM per
// channel, registered press/release pulses and a long-press (optionally repeating) pulse.
module multi_button_debouncer #(
  parameter int                  CHANNELS     = 4,
  parameter int                  TICK_DIVIDER = 12000,
  parameter int                  STABLE_TICKS = 20,
  parameter int                  HOLD_TICKS   = 1000,
  parameter int                  AUTO_REPEAT  = 0,
  parameter int                  REPEAT_TICKS = 250,
  parameter logic [CHANNELS-1:0] POLARITY     = '0
) (
  input  logic                   masterClock,
  input  logic                   reset,
  multi_button_debouncer_if.slave btn
);

  localparam int HOLD_CAP = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_MAX  = (STABLE_TICKS > HOLD_CAP) ? STABLE_TICKS : HOLD_CAP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int PRE_W    = $clog2(TICK_DIVIDER);
  localparam bit REPEAT_EN = (AUTO_REPEAT != 0);
  // With repeat enabled the hold counter parks at HOLD_TICKS and rep_q takes over.
  localparam int HOLD_SAT = REPEAT_EN ? HOLD_TICKS : HOLD_CAP;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_FIRE   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] HOLD_TOP    = CNT_W'(HOLD_SAT);
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIVIDER - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] cap);
    return (cnt == cap) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [PRE_W-1:0]    pre_q;
  logic                tick;
  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;

  state_t [CHANNELS-1:0]            state_q, state_d;
  logic   [CHANNELS-1:0][CNT_W-1:0] db_q, db_d;
  logic   [CHANNELS-1:0][CNT_W-1:0] hold_q, hold_d;
  logic   [CHANNELS-1:0][CNT_W-1:0] rep_q, rep_d;
  logic   [CHANNELS-1:0]            press_evt, rel_evt;
  logic   [CHANNELS-1:0]            level_q, level_d;
  logic   [CHANNELS-1:0]            pressed_q, pressed_d;
  logic   [CHANNELS-1:0]            released_q, released_d;
  logic   [CHANNELS-1:0]            held_q, held_d;

  assign tick = (pre_q == PRE_LAST);

  // Stage p0/p1: two-flop synchroniser after polarity normalisation
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      pre_q   <= tick ? '0 : pre_q + PRE_W'(1);
      sync_p0 <= btn.buttons ^ POLARITY;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-channel FSM and event registers
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= RELEASED;
      db_q       <= '0;
      hold_q     <= '0;
      rep_q      <= '0;
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      held_q     <= '0;
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      held_q     <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_evt = '0;
    rel_evt   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Hold timing runs on level, so release glitches do not disturb it.
      if (level_q[i] && tick) begin
        hold_d[i] = sat_inc(hold_q[i], HOLD_TOP);
        if (REPEAT_EN && hold_q[i] == HOLD_TOP)
          rep_d[i] = (rep_q[i] == REP_LAST) ? '0 : rep_q[i] + CNT_W'(1);
      end
      case (state_q[i])
        RELEASED: begin
          if (sync_p1[i]) begin
            state_d[i] = PRESS_CHK;
            db_d[i]    = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync_p1[i]) begin
            state_d[i] = RELEASED;
            db_d[i]    = '0;
          end else if (tick) begin
            if (db_q[i] == STABLE_LAST) begin
              state_d[i]   = PRESSED;
              db_d[i]      = '0;
              hold_d[i]    = '0;
              rep_d[i]     = '0;
              press_evt[i] = 1'b1;
            end else begin
              db_d[i] = db_q[i] + CNT_W'(1);
            end
          end
        end
        PRESSED: begin
          if (!sync_p1[i]) begin
            state_d[i] = RELEASE_CHK;
            db_d[i]    = '0;
          end
        end
        RELEASE_CHK: begin
          if (sync_p1[i]) begin
            state_d[i] = PRESSED;
          end else if (tick) begin
            if (db_q[i] == STABLE_LAST) begin
              state_d[i] = RELEASED;
              db_d[i]    = '0;
              hold_d[i]  = '0;
              rep_d[i]   = '0;
              rel_evt[i] = 1'b1;
            end else begin
              db_d[i] = db_q[i] + CNT_W'(1);
            end
          end
        end
        default: state_d[i] = RELEASED;
      endcase
    end
  end

  always_comb begin
    level_d    = level_q;
    pressed_d  = press_evt;
    released_d = rel_evt;
    held_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (press_evt[i]) level_d[i] = 1'b1;
      if (rel_evt[i])   level_d[i] = 1'b0;
      // A release on the same tick cancels any pending hold or repeat pulse.
      if (level_q[i] && tick && !rel_evt[i]) begin
        held_d[i] = (hold_q[i] != HOLD_TOP && hold_q[i] + CNT_W'(1) == HOLD_FIRE) ||
                    (REPEAT_EN && hold_q[i] == HOLD_TOP && rep_q[i] == REP_LAST);
      end
    end
  end

  assign btn.level    = level_q;
  assign btn.pressed  = pressed_q;
  assign btn.released = released_q;
  assign btn.held     = held_q;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer: one DUT without and one with auto-repeat,
// sharing the same button pins; pulse counts and cycles are logged per channel.
module tb_multi_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] buttons = 2'b10;
  int         cyc;
  int         total = 0;
  int         bad = 0;
  int         epoch = 0;
  int         seen = 0;

  int ev_n     [2][3][2];
  int ev_first [2][3][2];
  int ev_last  [2][3][2];
  logic [1:0] ev_w [2][3];

  multi_button_debouncer_if #(.CHANNELS(2)) bus0 ();
  multi_button_debouncer_if #(.CHANNELS(2)) bus1 ();

  assign bus0.buttons = buttons;
  assign bus1.buttons = buttons;

  multi_button_debouncer #(
    .CHANNELS(2), .TICK_DIVIDER(4), .STABLE_TICKS(3), .HOLD_TICKS(10),
    .AUTO_REPEAT(0), .REPEAT_TICKS(4), .POLARITY(2'b10)
  ) dut_single (.masterClock(clk), .reset(rst_n), .btn(bus0));

  multi_button_debouncer #(
    .CHANNELS(2), .TICK_DIVIDER(4), .STABLE_TICKS(3), .HOLD_TICKS(10),
    .AUTO_REPEAT(1), .REPEAT_TICKS(4), .POLARITY(2'b10)
  ) dut_repeat (.masterClock(clk), .reset(rst_n), .btn(bus1));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  assign ev_w[0][0] = bus0.pressed;
  assign ev_w[0][1] = bus0.released;
  assign ev_w[0][2] = bus0.held;
  assign ev_w[1][0] = bus1.pressed;
  assign ev_w[1][1] = bus1.released;
  assign ev_w[1][2] = bus1.held;

  // event log; a new epoch from the stimulus side clears it
  always @(negedge clk) begin
    if (seen != epoch) begin
      seen <= epoch;
      for (int d = 0; d < 2; d++)
        for (int e = 0; e < 3; e++)
          for (int c = 0; c < 2; c++) begin
            ev_n[d][e][c]     <= 0;
            ev_first[d][e][c] <= -1;
            ev_last[d][e][c]  <= -1;
          end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int e = 0; e < 3; e++)
          for (int c = 0; c < 2; c++)
            if (ev_w[d][e][c]) begin
              if (ev_n[d][e][c] == 0) ev_first[d][e][c] <= cyc;
              ev_last[d][e][c] <= cyc;
              ev_n[d][e][c]    <= ev_n[d][e][c] + 1;
            end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic go_to(input int c);
    int guard = 0;
    while (cyc < c && guard < 10000) begin
      @(posedge clk); #2;
      guard++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n   = 1'b0;
    buttons = 2'b10;
    repeat (3) @(posedge clk);
    #2;
    epoch++;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({bus0.level, bus0.pressed, bus0.released, bus0.held} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs_single got=%h want=00", {bus0.level, bus0.pressed, bus0.released, bus0.held});
    end
    total++;
    if ({bus1.level, bus1.pressed, bus1.released, bus1.held} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs_repeat got=%h want=00", {bus1.level, bus1.pressed, bus1.released, bus1.held});
    end
    go_to(40);
    total++;
    if (bus0.level !== 2'b00) begin
      bad++; $display("FAIL idle_level got=%b want=00", bus0.level);
    end
    total++;
    if (ev_n[0][0][0] + ev_n[0][0][1] + ev_n[1][0][0] + ev_n[1][0][1] != 0) begin
      bad++; $display("FAIL idle_pressed_count got=%0d want=0", ev_n[0][0][0] + ev_n[0][0][1] + ev_n[1][0][0] + ev_n[1][0][1]);
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    go_to(8);  buttons[0] = 1'b1;
    go_to(19);
    total++;
    if (bus0.level[0] !== 1'b0) begin
      bad++; $display("FAIL press_level_early got=%b want=0", bus0.level[0]);
    end
    go_to(20);
    total++;
    if (bus0.level[0] !== 1'b1) begin
      bad++; $display("FAIL press_level got=%b want=1", bus0.level[0]);
    end
    go_to(88); buttons[0] = 1'b0;
    go_to(130);
    total++;
    if (ev_n[0][0][0] !== 1 || ev_first[0][0][0] !== 20) begin
      bad++; $display("FAIL press_pulse got=%0d@%0d want=1@20", ev_n[0][0][0], ev_first[0][0][0]);
    end
    total++;
    if (ev_n[0][2][0] !== 1 || ev_first[0][2][0] !== 60) begin
      bad++; $display("FAIL press_held got=%0d@%0d want=1@60", ev_n[0][2][0], ev_first[0][2][0]);
    end
    total++;
    if (ev_n[0][1][0] !== 1 || ev_first[0][1][0] !== 100) begin
      bad++; $display("FAIL press_released got=%0d@%0d want=1@100", ev_n[0][1][0], ev_first[0][1][0]);
    end
    total++;
    if (bus0.level !== 2'b00) begin
      bad++; $display("FAIL press_level_after got=%b want=00", bus0.level);
    end
    total++;
    if (ev_n[0][0][1] + ev_n[0][1][1] + ev_n[0][2][1] != 0) begin
      bad++; $display("FAIL press_ch1_silent got=%0d want=0", ev_n[0][0][1] + ev_n[0][1][1] + ev_n[0][2][1]);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    go_to(8);
    for (int k = 0; k < 20; k++) begin
      buttons[0] = ~buttons[0];
      go_to(8 + 3 * (k + 1));
    end
    buttons[0] = 1'b0;
    go_to(120);
    total++;
    if (bus0.level[0] !== 1'b0 || bus1.level[0] !== 1'b0) begin
      bad++; $display("FAIL bounce_level got=%b%b want=00", bus0.level[0], bus1.level[0]);
    end
    total++;
    if (ev_n[0][0][0] + ev_n[0][1][0] + ev_n[0][2][0] + ev_n[1][0][0] + ev_n[1][1][0] + ev_n[1][2][0] != 0) begin
      bad++; $display("FAIL bounce_pulses got=%0d want=0",
                      ev_n[0][0][0] + ev_n[0][1][0] + ev_n[0][2][0] + ev_n[1][0][0] + ev_n[1][1][0] + ev_n[1][2][0]);
    end
  endtask

  task automatic test_auto_repeat();
    apply_reset();
    go_to(8);   buttons[0] = 1'b1;
    go_to(140); buttons[0] = 1'b0;
    go_to(180);
    total++;
    if (ev_n[1][2][0] !== 6) begin
      bad++; $display("FAIL repeat_count got=%0d want=6", ev_n[1][2][0]);
    end
    total++;
    if (ev_first[1][2][0] !== 60 || ev_last[1][2][0] !== 140) begin
      bad++; $display("FAIL repeat_span got=%0d..%0d want=60..140", ev_first[1][2][0], ev_last[1][2][0]);
    end
    total++;
    if (ev_n[0][2][0] !== 1 || ev_first[0][2][0] !== 60) begin
      bad++; $display("FAIL single_held got=%0d@%0d want=1@60", ev_n[0][2][0], ev_first[0][2][0]);
    end
    total++;
    if (ev_n[1][1][0] !== 1 || ev_first[1][1][0] !== 152) begin
      bad++; $display("FAIL repeat_released got=%0d@%0d want=1@152", ev_n[1][1][0], ev_first[1][1][0]);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    go_to(8);  buttons[0] = 1'b1;
    go_to(36); buttons[0] = 1'b0;
    go_to(40); buttons[0] = 1'b1;
    go_to(42);
    total++;
    if (bus0.level[0] !== 1'b1) begin
      bad++; $display("FAIL glitch_level got=%b want=1", bus0.level[0]);
    end
    go_to(88); buttons[0] = 1'b0;
    go_to(130);
    total++;
    if (ev_n[0][1][0] !== 1 || ev_first[0][1][0] !== 100) begin
      bad++; $display("FAIL glitch_released got=%0d@%0d want=1@100", ev_n[0][1][0], ev_first[0][1][0]);
    end
    total++;
    if (ev_n[0][2][0] !== 1 || ev_first[0][2][0] !== 60) begin
      bad++; $display("FAIL glitch_held got=%0d@%0d want=1@60", ev_n[0][2][0], ev_first[0][2][0]);
    end
    total++;
    if (ev_n[0][0][0] !== 1) begin
      bad++; $display("FAIL glitch_pressed got=%0d want=1", ev_n[0][0][0]);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    go_to(8);  buttons = 2'b01;
    go_to(30);
    total++;
    if (bus0.level !== 2'b11) begin
      bad++; $display("FAIL simul_level got=%b want=11", bus0.level);
    end
    go_to(40); buttons = 2'b10;
    go_to(70);
    total++;
    if (ev_n[0][0][0] !== 1 || ev_first[0][0][0] !== 20 || ev_n[0][0][1] !== 1 || ev_first[0][0][1] !== 20) begin
      bad++; $display("FAIL simul_pressed got=%0d@%0d,%0d@%0d want=1@20,1@20",
                      ev_n[0][0][0], ev_first[0][0][0], ev_n[0][0][1], ev_first[0][0][1]);
    end
    total++;
    if (ev_first[0][1][0] !== 52 || ev_first[0][1][1] !== 52) begin
      bad++; $display("FAIL simul_released got=%0d,%0d want=52,52", ev_first[0][1][0], ev_first[0][1][1]);
    end
    total++;
    if (bus0.level !== 2'b00) begin
      bad++; $display("FAIL simul_idle_level got=%b want=00", bus0.level);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    go_to(8);  buttons[0] = 1'b1;
    go_to(44);
    total++;
    if (bus0.level[0] !== 1'b1) begin
      bad++; $display("FAIL midrst_pre_level got=%b want=1", bus0.level[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus0.level, bus0.pressed, bus0.released, bus0.held, bus1.level, bus1.pressed, bus1.released, bus1.held} !== 16'h0000) begin
      bad++; $display("FAIL midrst_async got=%h want=0000",
                      {bus0.level, bus0.pressed, bus0.released, bus0.held, bus1.level, bus1.pressed, bus1.released, bus1.held});
    end
    repeat (3) @(posedge clk);
    #2;
    epoch++;
    rst_n = 1'b1;
    go_to(1);
    total++;
    if (bus0.pressed !== 2'b00 || bus0.level !== 2'b00) begin
      bad++; $display("FAIL midrst_after got=%b/%b want=00/00", bus0.pressed, bus0.level);
    end
    go_to(80);
    total++;
    if (ev_n[0][0][0] !== 1 || ev_first[0][0][0] !== 12) begin
      bad++; $display("FAIL midrst_pressed got=%0d@%0d want=1@12", ev_n[0][0][0], ev_first[0][0][0]);
    end
    total++;
    if (ev_n[0][2][0] !== 1 || ev_first[0][2][0] !== 52) begin
      bad++; $display("FAIL midrst_held got=%0d@%0d want=1@52", ev_n[0][2][0], ev_first[0][2][0]);
    end
    total++;
    if (ev_n[0][0][1] + ev_n[0][1][1] + ev_n[0][2][1] != 0) begin
      bad++; $display("FAIL midrst_ch1 got=%0d want=0", ev_n[0][0][1] + ev_n[0][1][1] + ev_n[0][2][1]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
